// File: rtl/register_file.sv
// Two-read, one-write register file with registered read ports; entry 0 is zero.
// Optional write-first forwarding on collisions: define REGFILE_BYPASS_EN.
module register_file #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_word_a;
    logic [WIDTH-1:0] rd_word_b;
    logic             wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_word_a = mem[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (wr_addr == rd_addr_a)) begin
            rd_word_a = wr_data;
        end
`endif
        if (rd_addr_a == '0) begin
            rd_word_a = '0;
        end
    end

    always_comb begin
        rd_word_b = mem[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (wr_addr == rd_addr_b)) begin
            rd_word_b = wr_data;
        end
`endif
        if (rd_addr_b == '0) begin
            rd_word_b = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) begin
                rd_data_a <= rd_word_a;
            end
            if (rd_en_b) begin
                rd_data_b <= rd_word_b;
            end
        end
    end

endmodule
